mode_register: RTL



---
 rtl/mode_register_pkg.sv | 41 ++++
 rtl/mode_register_next.sv | 78 +++++++
 rtl/mode_register.sv | 60 ++++++
 3 files changed

// File: rtl/mode_register_pkg.sv
// mode_register shared types: command enum and priority decoder.
// Used by mode_register and mode_register_next.
package mode_register_pkg;

  typedef enum logic [2:0] {
    CMD_HOLD = 3'd0,
    CMD_CLR  = 3'd1,
    CMD_LD   = 3'd2,
    CMD_INC  = 3'd3,
    CMD_DEC  = 3'd4,
    CMD_SHL  = 3'd5,
    CMD_SHR  = 3'd6
  } mode_cmd_e;

  // inc&dec together is a count no-op that
  // also masks the shift stage, so it is
  // decoded to hold before shifts are looked at.
  function automatic mode_cmd_e decode_cmd(
    input logic clr,
    input logic ld,
    input logic inc,
    input logic dec,
    input logic shl,
    input logic shr
  );
    mode_cmd_e c;
    c = CMD_HOLD;
    priority case (1'b1)
      clr:         c = CMD_CLR;
      ld:          c = CMD_LD;
      inc && !dec: c = CMD_INC;
      dec && !inc: c = CMD_DEC;
      inc && dec:  c = CMD_HOLD;
      shl && !shr: c = CMD_SHL;
      shr && !shl: c = CMD_SHR;
      default:     c = CMD_HOLD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mode_register_next.sv
// mode_register next-state logic (purely combinational).
// MODE_REGISTER_SATURATE_EN: count saturates instead of wrapping.
module mode_register_next
  import mode_register_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] MOD_MAX = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  mode_cmd_e        cmd,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] din,
  input  logic             ser_in,
  input  logic             cur_ser,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap,
  output logic             ser_out
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

`ifdef MODE_REGISTER_SATURATE_EN
  localparam logic [WIDTH-1:0] UP_LIM = MOD_MAX;
  localparam logic [WIDTH-1:0] DN_LIM = '0;
`else
  localparam logic [WIDTH-1:0] UP_LIM = '0;
  localparam logic [WIDTH-1:0] DN_LIM = MOD_MAX;
`endif

  function automatic logic [WIDTH-1:0] clamp(
    input logic [WIDTH-1:0] v
  );
    return (v > MOD_MAX) ? MOD_MAX : v;
  endfunction

  logic [WIDTH-1:0] sl_raw;
  logic [WIDTH-1:0] sr_raw;

  assign sl_raw = {cur[WIDTH-2:0], ser_in};
  assign sr_raw = {ser_in, cur[WIDTH-1:1]};

  // Select next value, wrap pulse and serial bit
  always_comb begin
    nxt     = cur;
    wrap    = 1'b0;
    ser_out = cur_ser;
    unique case (cmd)
      CMD_CLR: nxt = RST_VAL;
      CMD_LD:  nxt = clamp(din);
      CMD_INC: begin
        if (cur >= MOD_MAX) begin
          nxt  = UP_LIM;
          wrap = 1'b1;
        end else begin
          nxt = cur + ONE;
        end
      end
      CMD_DEC: begin
        if (cur == '0) begin
          nxt  = DN_LIM;
          wrap = 1'b1;
        end else begin
          nxt = cur - ONE;
        end
      end
      CMD_SHL: begin
        nxt     = clamp(sl_raw);
        ser_out = cur[WIDTH-1];
      end
      CMD_SHR: begin
        nxt     = clamp(sr_raw);
        ser_out = cur[0];
      end
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/mode_register.sv
// mode_register: load/count/shift register, registers only.
// MODE_REGISTER_SATURATE_EN: count saturates instead of wrapping.
module mode_register
  import mode_register_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] MOD_MAX = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic             inc,
  input  logic             dec,
  input  logic             shl,
  input  logic             shr,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             ser_out
);

  mode_cmd_e        cmd;
  logic [WIDTH-1:0] nxt;
  logic             nxt_wrap;
  logic             nxt_ser;

  assign cmd = decode_cmd(clr, ld, inc, dec, shl, shr);

  mode_register_next #(
    .WIDTH   (WIDTH),
    .MOD_MAX (MOD_MAX),
    .RST_VAL (RST_VAL)
  ) u_next (
    .cmd     (cmd),
    .cur     (out),
    .din     (in),
    .ser_in  (ser_in),
    .cur_ser (ser_out),
    .nxt     (nxt),
    .wrap    (nxt_wrap),
    .ser_out (nxt_ser)
  );

  // State registers, async reset to RST_VAL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out     <= RST_VAL;
      wrap    <= 1'b0;
      ser_out <= 1'b0;
    end else begin
      out     <= nxt;
      wrap    <= nxt_wrap;
      ser_out <= nxt_ser;
    end
  end

endmodule
